// File: rtl/color_pkg.sv
// Shared constants and types for the colour-generator phase path.
package color_pkg;
  localparam int          PHASE_W    = 16;
  localparam int          SINCOS_W   = 32;
  localparam logic [15:0] PI_Q13     = 16'h6487;
  localparam logic [16:0] TWO_PI_Q13 = 17'hC90E;

  typedef logic signed [PHASE_W-1:0] phase_t;
endpackage

// File: rtl/cordic_phase_arbiter_tag_delay_line.sv
// Fixed-depth shift register for {valid, id} tags; every stage is exposed so
// the owner can tell whether anything is still in flight.
module tag_delay_line #(
  parameter int DEPTH = 20,
  parameter int W     = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [W-1:0]              d_i,
  output logic [DEPTH-1:0][W-1:0]   taps_o,
  output logic [W-1:0]              q_o
);
  logic [DEPTH-1:0][W-1:0] pipe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign taps_o = pipe_q;
  assign q_o    = pipe_q[DEPTH-1];
endmodule

// File: rtl/cordic_phase_arbiter.sv
// Round-robin sharing of one pipelined CORDIC sin/cos core among NUM_REQ
// requesters, with phase wrap into [-PI, PI] and tag-based result routing.
module cordic_phase_arbiter
  import color_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int LATENCY = 20,
  parameter int RAW_W   = 19
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*RAW_W-1:0]   req_phase,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       cordic_valid,
  output logic [PHASE_W-1:0]         cordic_phase,
  input  logic [SINCOS_W-1:0]        cordic_dout,
  output logic [NUM_REQ-1:0]         resp_valid,
  output logic [SINCOS_W-1:0]        resp_sincos,
  output logic                       busy,
  output logic                       wrap_err
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TAG_W = ID_W + 1;
  localparam int EXT_W = RAW_W + 2;

  localparam logic signed [EXT_W-1:0] PI_E     = EXT_W'(PI_Q13);
  localparam logic signed [EXT_W-1:0] TWO_PI_E = EXT_W'(TWO_PI_Q13);
  localparam logic signed [EXT_W-1:0] NEG_PI_E = -PI_E;

  logic [ID_W-1:0]            rr_q, rr_d;
  logic [NUM_REQ-1:0]         grant;
  logic                       gnt_any;
  logic [ID_W-1:0]            gnt_id;
  logic signed [RAW_W-1:0]    raw;
  int                         ix;

  logic signed [EXT_W-1:0]    p_ext, p_cor, p_wr;
  logic                       clamp;

  logic                       cv_q;
  phase_t                     ph_q;
  logic [TAG_W-1:0]           tag_q;
  logic                       err_q;
  logic [NUM_REQ-1:0]         rv_q;
  logic [SINCOS_W-1:0]        sc_q;

  logic [LATENCY-1:0][TAG_W-1:0] dl_taps;
  logic [TAG_W-1:0]           dl_tag;
  logic                       dl_any;

  // Search starts at rr_ptr and wraps; first valid requester wins.
  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    raw     = '0;
    rr_d    = rr_q;
    ix      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      ix = int'(rr_q) + k;
      if (ix >= NUM_REQ) ix = ix - NUM_REQ;
      if (!gnt_any && req_valid[ix]) begin
        gnt_any   = 1'b1;
        grant[ix] = 1'b1;
        gnt_id    = ID_W'(ix);
        raw       = req_phase[ix*RAW_W +: RAW_W];
        rr_d      = (ix == NUM_REQ-1) ? '0 : ID_W'(ix + 1);
      end
    end
  end

  // One 2PI correction; anything still out of range came from beyond +/-3PI.
  always_comb begin
    p_ext = EXT_W'(raw);
    if (p_ext > PI_E)          p_cor = p_ext - TWO_PI_E;
    else if (p_ext < NEG_PI_E) p_cor = p_ext + TWO_PI_E;
    else                       p_cor = p_ext;
    clamp = 1'b0;
    p_wr  = p_cor;
    if (p_cor > PI_E) begin
      p_wr  = PI_E;
      clamp = 1'b1;
    end else if (p_cor < NEG_PI_E) begin
      p_wr  = NEG_PI_E;
      clamp = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q  <= '0;
      cv_q  <= 1'b0;
      ph_q  <= '0;
      tag_q <= '0;
      err_q <= 1'b0;
    end else begin
      rr_q  <= rr_d;
      cv_q  <= gnt_any;
      tag_q <= {gnt_any, gnt_id};
      if (gnt_any) ph_q <= phase_t'(p_wr[PHASE_W-1:0]);
      if (gnt_any && clamp) err_q <= 1'b1;
    end
  end

  tag_delay_line #(.DEPTH(LATENCY), .W(TAG_W)) u_tag_dl (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (tag_q),
    .taps_o (dl_taps),
    .q_o    (dl_tag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv_q <= '0;
      sc_q <= '0;
    end else begin
      rv_q <= dl_tag[ID_W] ? (NUM_REQ'(1) << dl_tag[ID_W-1:0]) : '0;
      if (dl_tag[ID_W]) sc_q <= cordic_dout;
    end
  end

  always_comb begin
    dl_any = 1'b0;
    for (int i = 0; i < LATENCY; i++) dl_any = dl_any | dl_taps[i][ID_W];
  end

  assign req_ready    = grant;
  assign cordic_valid = cv_q;
  assign cordic_phase = ph_q;
  assign resp_valid   = rv_q;
  assign resp_sincos  = sc_q;
  assign wrap_err     = err_q;
  assign busy         = tag_q[ID_W] | dl_any | (|rv_q);
endmodule

// File: tb/tb_cordic_phase_arbiter.sv
// Scoreboard bench: directed issues push expected results; a monitor checks
// each response's owner, data and arrival cycle against the queue head.
module tb_cordic_phase_arbiter;
  localparam int NUM_REQ = 2;
  localparam int LATENCY = 20;
  localparam int RAW_W   = 19;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ*RAW_W-1:0] req_phase = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     cordic_valid;
  logic [15:0]              cordic_phase;
  logic [31:0]              cordic_dout;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [31:0]              resp_sincos;
  logic                     busy;
  logic                     wrap_err;

  cordic_phase_arbiter #(.NUM_REQ(NUM_REQ), .LATENCY(LATENCY), .RAW_W(RAW_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_phase    (req_phase),
    .req_ready    (req_ready),
    .cordic_valid (cordic_valid),
    .cordic_phase (cordic_phase),
    .cordic_dout  (cordic_dout),
    .resp_valid   (resp_valid),
    .resp_sincos  (resp_sincos),
    .busy         (busy),
    .wrap_err     (wrap_err)
  );

  always #5 clk = ~clk;

  // Behavioural core: phase delayed LATENCY cycles, returned as {phase, ~phase}.
  logic [15:0] core_pipe [LATENCY];
  always @(posedge clk) begin
    for (int i = LATENCY-1; i > 0; i--) core_pipe[i] <= core_pipe[i-1];
    core_pipe[0] <= cordic_phase;
  end
  assign cordic_dout = {core_pipe[LATENCY-1], ~core_pipe[LATENCY-1]};

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [NUM_REQ-1:0] owner;
    logic [31:0]        data;
    int                 due;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response must match the oldest expectation, on its due cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (resp_valid !== '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 32'(resp_valid), 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_owner", 32'(resp_valid), 32'(e.owner));
          chk("resp_sincos", resp_sincos, e.data);
          chk("resp_cycle", cyc, e.due);
        end
      end else if (sb.size() != 0 && cyc > sb[0].due) begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_missing", 32'(resp_valid), 32'(e.owner));
      end
    end
  end

  // Drive one cycle of requests; check grant, and the issued phase after the edge.
  task automatic issue(input logic [1:0] v, input logic signed [RAW_W-1:0] p0,
                       input logic signed [RAW_W-1:0] p1, input logic [1:0] eg,
                       input logic [15:0] eph);
    exp_t e;
    req_valid = v;
    req_phase = {p1, p0};
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(eg));
    if (eg != '0) begin
      e.owner = eg;
      e.data  = {eph, ~eph};
      e.due   = cyc + LATENCY + 2;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    chk("cordic_valid", 32'(cordic_valid), 32'(eg != '0));
    if (eg != '0) chk("cordic_phase", 32'(cordic_phase), 32'(eph));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(2'b00, '0, '0, 2'b00, 16'h0);
  endtask

  initial begin
    for (int i = 0; i < LATENCY; i++) core_pipe[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cordic_valid", 32'(cordic_valid), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_wrap_err", 32'(wrap_err), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Both valid from reset: strict alternation 0,1,0,1,0,1.
    for (int k = 0; k < 6; k++) begin
      logic [15:0] e0, e1;
      e0 = 16'(1000 + k);
      e1 = 16'(-2000 - k);
      issue(2'b11, RAW_W'(1000 + k), RAW_W'(-2000 - k),
            (k % 2 == 0) ? 2'b01 : 2'b10, (k % 2 == 0) ? e0 : e1);
    end
    // Req0 only: 30000 wraps to -21470.
    issue(2'b01, 19'sd30000, '0, 2'b01, 16'hAC22);
    // Values already in range pass through untouched.
    issue(2'b01, 19'sd0, '0, 2'b01, 16'h0000);
    issue(2'b01, 19'sd25735, '0, 2'b01, 16'h6487);
    issue(2'b01, -19'sd25735, '0, 2'b01, 16'h9B79);
    chk("wrap_err_in_range", 32'(wrap_err), 32'h0);
    // Beyond 3PI: clamp, sticky error.
    issue(2'b10, '0, 19'sd200000, 2'b10, 16'h6487);
    chk("wrap_err_set", 32'(wrap_err), 32'h1);
    issue(2'b01, -19'sd30000, '0, 2'b01, 16'h53DE);
    issue(2'b10, '0, -19'sd200000, 2'b10, 16'h9B79);
    idle(2);
    chk("wrap_err_sticky", 32'(wrap_err), 32'h1);
    chk("rr_ptr_pre", 32'(dut.rr_q), 32'h0);
    // Req1 alone three times, then both: 1,1,1 then 0,1.
    issue(2'b10, '0, 19'sd100, 2'b10, 16'd100);
    issue(2'b10, '0, 19'sd101, 2'b10, 16'd101);
    issue(2'b10, '0, 19'sd102, 2'b10, 16'd102);
    chk("rr_ptr_after_req1", 32'(dut.rr_q), 32'h0);
    issue(2'b11, 19'sd200, 19'sd300, 2'b01, 16'd200);
    chk("rr_ptr_after_g0", 32'(dut.rr_q), 32'h1);
    issue(2'b11, 19'sd201, 19'sd301, 2'b10, 16'd301);
    chk("rr_ptr_after_g1", 32'(dut.rr_q), 32'h0);
    idle(LATENCY + 5);
    chk("drained_busy", 32'(busy), 32'h0);
    chk("drained_sb", sb.size(), 0);

    // Reset mid-stream: four in flight are lost.
    issue(2'b11, 19'sd11, 19'sd12, 2'b01, 16'd11);
    issue(2'b11, 19'sd13, 19'sd14, 2'b10, 16'd14);
    issue(2'b11, 19'sd15, 19'sd16, 2'b01, 16'd15);
    issue(2'b11, 19'sd17, 19'sd18, 2'b10, 16'd18);
    idle(5);
    chk("inflight_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_cordic_valid", 32'(cordic_valid), 32'h0);
    chk("mid_rst_cordic_phase", 32'(cordic_phase), 32'h0);
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("mid_rst_resp_sincos", resp_sincos, 32'h0);
    chk("mid_rst_wrap_err", 32'(wrap_err), 32'h0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < LATENCY + 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_resp", 32'(resp_valid), 32'h0);
    end
    chk("post_rst_busy", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule
